// File: rtl/mc14599_latch.sv
// Addressable output latch for the MC14500B ICU: latch, demux, toggle and
// timed-pulse writes, with synchronous clear-all and addressed readback.
module mc14599_latch #(
    parameter int WIDTH     = 8,
    parameter int AW        = 3,
    parameter int PULSE_LEN = 4,
    parameter int CW        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wd,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    a,
    input  logic             dat,
    output logic [WIDTH-1:0] q,
    output logic             rd,
    output logic             busy
);

    localparam logic [1:0] MODE_LATCH  = 2'b00;
    localparam logic [1:0] MODE_DEMUX  = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [1:0] MODE_PULSE  = 2'b11;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);

    logic [WIDTH-1:0]         q_q, q_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;

        // Background expiry; an addressed write below overrides its own bit.
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
                if (cnt_q[i] == CNT_ONE) begin
                    q_d[i] = 1'b0;
                end
            end
        end

        if (clr) begin
            q_d   = '0;
            cnt_d = '0;
        end else if (!wd) begin
            unique case (mode)
                MODE_LATCH: begin
                    cnt_d[a] = '0;
                    q_d[a]   = dat;
                end
                MODE_DEMUX: begin
                    q_d      = '0;
                    cnt_d    = '0;
                    q_d[a]   = dat;
                end
                MODE_TOGGLE: begin
                    cnt_d[a] = '0;
                    q_d[a]   = dat ? ~q_q[a] : q_q[a];
                end
                MODE_PULSE: begin
                    q_d[a]   = dat;
                    cnt_d[a] = dat ? CNT_LOAD : '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q    = q_q;
    assign rd   = q_q[a];
    assign busy = |cnt_q;

endmodule

// File: tb/tb_mc14599_latch.sv
// Self-checking bench for mc14599_latch: directed test-plan sequences with
// literal expectations, then randomized traffic against a behavioural model.
module tb_mc14599_latch;

    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wd  = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [2:0] a   = 3'd0;
    logic       dat = 1'b0;
    logic [7:0] q;
    logic       rd;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: per-bit output value and remaining high cycles of a running pulse.
    logic [7:0] mq = 8'h00;
    int         mrem[8];

    mc14599_latch #(.WIDTH(8), .AW(3), .PULSE_LEN(PL), .CW(3)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wd(wd), .mode(mode),
        .a(a), .dat(dat), .q(q), .rd(rd), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq = 8'h00;
        for (int i = 0; i < 8; i++) mrem[i] = 0;
    endfunction

    function automatic bit model_busy();
        bit b = 1'b0;
        for (int i = 0; i < 8; i++) if (mrem[i] > 0) b = 1'b1;
        return b;
    endfunction

    // One rising edge worth of behaviour, written from the mode rules.
    function automatic void model_step(logic c, logic w, logic [1:0] m,
                                       logic [2:0] ad, logic d);
        int idx = int'(ad);
        if (c) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 8; i++) begin
            if (mrem[i] > 0 && (w || i != idx)) begin
                mrem[i] = mrem[i] - 1;
                if (mrem[i] == 0) mq[i] = 1'b0;
            end
        end
        if (!w) begin
            case (m)
                2'd0: begin mq[idx] = d; mrem[idx] = 0; end
                2'd1: begin model_reset(); mq[idx] = d; end
                2'd2: begin if (d) mq[idx] = ~mq[idx]; mrem[idx] = 0; end
                default: begin mq[idx] = d; mrem[idx] = d ? PL : 0; end
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", q, mq);
            check("model_busy", {7'd0, busy}, {7'd0, model_busy()});
            check("model_rd", {7'd0, rd}, {7'd0, mq[a]});
        end
    end

    task automatic drive(input logic c, input logic w, input logic [1:0] m,
                         input logic [2:0] ad, input logic d);
        clr = c; wd = w; mode = m; a = ad; dat = d;
        @(posedge clk);
        model_step(c, w, m, ad, d);
        #1;
    endtask

    task automatic wr(input logic [1:0] m, input logic [2:0] ad, input logic d);
        drive(1'b0, 1'b0, m, ad, d);
    endtask

    task automatic idle(input logic [2:0] ad);
        drive(1'b0, 1'b1, 2'b00, ad, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b1, 2'b00, 3'd0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_q", q, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        check("reset_rd", {7'd0, rd}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Asynchronous reset in the middle of a pulse.
        wr(2'b11, 3'd4, 1'b1);
        check("pre_rst_q", q, 8'h10);
        check("pre_rst_busy", {7'd0, busy}, 8'h01);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_q", q, 8'h00);
        check("async_rst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wr(2'b00, 3'd2, 1'b1);
        check("post_rst_write", q, 8'h04);

        // Latch and readback.
        do_clr();
        wr(2'b00, 3'd0, 1'b1);
        wr(2'b00, 3'd3, 1'b1);
        wr(2'b00, 3'd7, 1'b1);
        check("latch_q", q, 8'h89);
        idle(3'd3);
        check("rd_a3", {7'd0, rd}, 8'h01);
        idle(3'd4);
        check("rd_a4", {7'd0, rd}, 8'h00);
        drive(1'b1, 1'b0, 2'b00, 3'd1, 1'b1);
        check("clr_over_write", q, 8'h00);

        // Demux and toggle.
        for (int i = 4; i < 8; i++) wr(2'b00, 3'(i), 1'b1);
        check("setup_f0", q, 8'hF0);
        wr(2'b01, 3'd1, 1'b1);
        check("demux", q, 8'h02);
        wr(2'b10, 3'd1, 1'b1);
        check("toggle_1", q, 8'h00);
        wr(2'b10, 3'd5, 1'b0);
        check("toggle_0", q, 8'h00);

        // Pulse timing.
        wr(2'b11, 3'd6, 1'b1);
        for (int k = 0; k < PL; k++) begin
            check("pulse_high", q, 8'h40);
            check("pulse_busy", {7'd0, busy}, 8'h01);
            idle(3'd6);
        end
        check("pulse_end", q, 8'h00);
        check("pulse_end_busy", {7'd0, busy}, 8'h00);

        // Retrigger: high through k+5, low after k+6.
        wr(2'b11, 3'd2, 1'b1);
        idle(3'd2);
        wr(2'b11, 3'd2, 1'b1);
        idle(3'd2);
        idle(3'd2);
        idle(3'd2);
        check("retrig_k5", q, 8'h04);
        idle(3'd2);
        check("retrig_k6", q, 8'h00);

        // Latch write cancels a running pulse, bit stays set.
        wr(2'b11, 3'd3, 1'b1);
        wr(2'b00, 3'd3, 1'b1);
        repeat (6) idle(3'd3);
        check("cancel_q", q, 8'h08);
        check("cancel_busy", {7'd0, busy}, 8'h00);

        // Overlapping pulses plus a write on another bit's expiry edge.
        do_clr();
        wr(2'b11, 3'd0, 1'b1);
        wr(2'b11, 3'd1, 1'b1);
        idle(3'd0);
        idle(3'd0);
        wr(2'b00, 3'd7, 1'b1);
        check("conc_k4", q, 8'h82);
        check("conc_k4_busy", {7'd0, busy}, 8'h01);
        idle(3'd0);
        check("conc_k5", q, 8'h80);
        check("conc_k5_busy", {7'd0, busy}, 8'h00);

        // Randomized traffic; writes kept sparse so pulses get to expire.
        for (int n = 0; n < 3000; n++) begin
            int r = int'($urandom_range(0, 199));
            if (r == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk);
                model_step(clr, wd, mode, a, dat);
                #1;
            end else if (r < 4) begin
                do_clr();
            end else if (r < 80) begin
                drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) != 0));
            end else begin
                idle(3'($urandom_range(0, 7)));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
